// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole field: level encodings, the
// RUN/OVER game state, and the level-to-lifetime and level-to-points tables.
package whack_pkg;

    localparam logic [1:0] LVL_0 = 2'd0;
    localparam logic [1:0] LVL_1 = 2'd1;
    localparam logic [1:0] LVL_2 = 2'd2;

    typedef logic [0:0] state_t;
    localparam state_t RUN  = 1'b0;
    localparam state_t OVER = 1'b1;

    // Level 3 falls into the default arm, so it behaves exactly like level 2.
    function automatic logic [31:0] life_of(input logic [1:0] lvl,
                                            input logic [31:0] life0,
                                            input logic [31:0] life1,
                                            input logic [31:0] life2);
        case (lvl)
            LVL_0:   return life0;
            LVL_1:   return life1;
            default: return life2;
        endcase
    endfunction

    function automatic logic [1:0] points_of(input logic [1:0] lvl);
        case (lvl)
            LVL_0:   return 2'd1;
            LVL_1:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/whack_field_if.sv
// Spawn request channel from the RNG into the field (valid/ready handshake).
// The producer holds valid and index stable until it sees ready.
interface whack_field_if #(
    parameter int N_LANES = 18
);
    localparam int IDX_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

    logic             spawn_valid;
    logic [IDX_W-1:0] spawn_index;
    logic             spawn_ready;

    modport master (output spawn_valid, output spawn_index, input spawn_ready);
    modport slave  (input spawn_valid, input spawn_index, output spawn_ready);

endinterface

// File: rtl/whack_lane.sv
// One target of the field: lit flag, countdown timer and the level latched
// when the lane was lit. Reports a hit or an expiry to the parent, which owns
// all scoring. A hit on the same cycle as the final timer tick wins.
module whack_lane
    import whack_pkg::*;
#(
    parameter int TIMER_W = 26
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] life_i,
    input  logic [1:0]         level_i,
    input  logic               edge_i,
    output logic               lit_o,
    output logic               hit_o,
    output logic               expire_o,
    output logic [1:0]         level_o
);

    logic               lit_q, lit_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [1:0]         level_q, level_d;

    assign hit_o    = lit_q & edge_i;
    assign expire_o = lit_q & (timer_q == TIMER_W'(1)) & ~edge_i;
    assign lit_o    = lit_q;
    assign level_o  = level_q;

    // Clear beats load beats hit/expiry; a lit lane otherwise counts down by one.
    always_comb begin
        lit_d   = lit_q;
        timer_d = timer_q;
        level_d = level_q;
        if (clear_i) begin
            lit_d   = 1'b0;
            timer_d = '0;
        end else if (load_i) begin
            lit_d   = 1'b1;
            timer_d = life_i;
            level_d = level_i;
        end else if (hit_o || expire_o) begin
            lit_d   = 1'b0;
            timer_d = '0;
        end else if (lit_q) begin
            timer_d = timer_q - TIMER_W'(1);
        end
    end

    // Lane state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lit_q   <= 1'b0;
            timer_q <= '0;
            level_q <= LVL_0;
        end else begin
            lit_q   <= lit_d;
            timer_q <= timer_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/whack_field.sv
// Multi-target whack-a-mole engine. Accepts spawn requests over
// whack_field_if, keeps up to MAX_ACTIVE lanes lit, scores rising switch
// edges on lit lanes and counts expiries as misses until the game ends.
// Optional build macro WHACK_PENALTY_EN: a rising edge on an unlit lane
// during play takes one point off the score (never below zero).
module whack_field
    import whack_pkg::*;
#(
    parameter int N_LANES    = 18,
    parameter int MAX_ACTIVE = 4,
    parameter int TIMER_W    = 26,
    parameter int SCORE_W    = 8,
    parameter int MISS_W     = 4,
    parameter int MAX_MISSES = 10,
    parameter int LIFE0      = 50_000_000,
    parameter int LIFE1      = 25_000_000,
    parameter int LIFE2      = 12_500_000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [1:0]         level_i,
    input  logic               restart_i,
    whack_field_if.slave       spawn_if,
    input  logic [N_LANES-1:0] sw_i,
    output logic [N_LANES-1:0] led_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [MISS_W-1:0]  misses_o,
    output logic               hit_pulse_o,
    output logic               miss_pulse_o,
    output logic               game_over_o
);

    localparam int          IDX_W     = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam logic [31:0] SCORE_MAX = 32'((64'd1 << SCORE_W) - 64'd1);
    localparam logic [31:0] MISS_MAX  = 32'((64'd1 << MISS_W) - 64'd1);

    logic [N_LANES-1:0] lit, hit, expire, load, edgeRun;
    logic [N_LANES-1:0] swPrev_q;
    logic [1:0]         laneLevel [N_LANES];
    logic [TIMER_W-1:0] lifeNow;
    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [MISS_W-1:0]  misses_q, misses_d;
    logic               hitPulse_q, hitPulse_d;
    logic               missPulse_q, missPulse_d;
    logic [31:0]        activeCount, hitPoints, expCount, scoreSum, missSum;
    logic [IDX_W-1:0]   spawnIdx;
    logic               idxOk, spawnReady, accept, laneClear;
`ifdef WHACK_PENALTY_EN
    logic [31:0]        penCount;
`endif

    assign spawnIdx = spawn_if.spawn_index;
    assign idxOk    = 32'(spawnIdx) < 32'(N_LANES);
    assign lifeNow  = TIMER_W'(life_of(level_i, 32'(LIFE0), 32'(LIFE1), 32'(LIFE2)));
    assign edgeRun  = (state_q == RUN) ? (sw_i & ~swPrev_q) : '0;
    assign accept   = spawn_if.spawn_valid & spawnReady;
    assign laneClear = restart_i | (state_d == OVER);

    for (genvar g = 0; g < N_LANES; g++) begin : gLane
        whack_lane #(
            .TIMER_W (TIMER_W)
        ) uLane (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .clear_i  (laneClear),
            .load_i   (load[g]),
            .life_i   (lifeNow),
            .level_i  (level_i),
            .edge_i   (edgeRun[g]),
            .lit_o    (lit[g]),
            .hit_o    (hit[g]),
            .expire_o (expire[g]),
            .level_o  (laneLevel[g])
        );
    end

    // Tally lit lanes, hit points and expiries across the whole field this cycle.
    always_comb begin
        activeCount = '0;
        hitPoints   = '0;
        expCount    = '0;
        for (int i = 0; i < N_LANES; i++) begin
            activeCount = activeCount + 32'(lit[i]);
            expCount    = expCount + 32'(expire[i]);
            if (hit[i]) begin
                hitPoints = hitPoints + 32'(points_of(laneLevel[i]));
            end
        end
    end

`ifdef WHACK_PENALTY_EN
    // Count rising edges that landed on unlit lanes during play.
    always_comb begin
        penCount = '0;
        for (int i = 0; i < N_LANES; i++) begin
            penCount = penCount + 32'(edgeRun[i] & ~lit[i]);
        end
    end
`endif

    // Ready also drops during restart so an accepted request is never wiped by the clear.
    always_comb begin
        spawnReady = 1'b0;
        if (state_q == RUN && !restart_i && activeCount < 32'(MAX_ACTIVE) && idxOk) begin
            spawnReady = ~lit[spawnIdx] & ~hit[spawnIdx] & ~expire[spawnIdx];
        end
    end

    // Decode an accepted request into a one-hot load for the target lane.
    always_comb begin
        load = '0;
        for (int i = 0; i < N_LANES; i++) begin
            if (accept && 32'(spawnIdx) == 32'(i)) begin
                load[i] = 1'b1;
            end
        end
    end

    // Saturating score and miss arithmetic; the penalty comes after hit points.
    always_comb begin
        scoreSum = 32'(score_q) + hitPoints;
        if (scoreSum > SCORE_MAX) begin
            scoreSum = SCORE_MAX;
        end
`ifdef WHACK_PENALTY_EN
        scoreSum = (scoreSum > penCount) ? (scoreSum - penCount) : '0;
`endif
        missSum = 32'(misses_q) + expCount;
        if (missSum > MISS_MAX) begin
            missSum = MISS_MAX;
        end
        score_d     = score_q;
        misses_d    = misses_q;
        hitPulse_d  = 1'b0;
        missPulse_d = 1'b0;
        if (restart_i) begin
            score_d  = '0;
            misses_d = '0;
        end else if (state_q == RUN) begin
            score_d     = SCORE_W'(scoreSum);
            misses_d    = MISS_W'(missSum);
            hitPulse_d  = |hit;
            missPulse_d = |expire;
        end
    end

    // Game state: restart always lands in RUN, the final miss moves RUN to OVER.
    always_comb begin
        state_d = state_q;
        if (restart_i) begin
            state_d = RUN;
        end else if (state_q == RUN && missSum >= 32'(MAX_MISSES)) begin
            state_d = OVER;
        end
    end

    // Game registers; the previous switch sample is reloaded on reset so no edge appears.
    always_ff @(posedge clk_i) begin
        swPrev_q <= sw_i;
        if (rst_i) begin
            state_q     <= RUN;
            score_q     <= '0;
            misses_q    <= '0;
            hitPulse_q  <= 1'b0;
            missPulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            misses_q    <= misses_d;
            hitPulse_q  <= hitPulse_d;
            missPulse_q <= missPulse_d;
        end
    end

    assign spawn_if.spawn_ready = spawnReady;
    assign led_o        = lit;
    assign score_o      = score_q;
    assign misses_o     = misses_q;
    assign hit_pulse_o  = hitPulse_q;
    assign miss_pulse_o = missPulse_q;
    assign game_over_o  = (state_q == OVER);

endmodule

// File: tb/tb_whack_field.sv
// Directed bench for whack_field with short lifetimes (20/10/5 clocks),
// two active lanes at most and three misses per game.
module tb_whack_field;

    localparam int N = 18;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         restart = 1'b0;
    logic [1:0]   level = 2'd0;
    logic [N-1:0] sw = '0;
    logic [N-1:0] led;
    logic [7:0]   score;
    logic [3:0]   misses;
    logic         hitPulse, missPulse, gameOver;
    int           checks = 0;
    int           errors = 0;
    int           waited;

    whack_field_if #(.N_LANES(N)) spawnBus();

    whack_field #(
        .N_LANES    (N),
        .MAX_ACTIVE (2),
        .TIMER_W    (26),
        .SCORE_W    (8),
        .MISS_W     (4),
        .MAX_MISSES (3),
        .LIFE0      (20),
        .LIFE1      (10),
        .LIFE2      (5)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .level_i      (level),
        .restart_i    (restart),
        .spawn_if     (spawnBus),
        .sw_i         (sw),
        .led_o        (led),
        .score_o      (score),
        .misses_o     (misses),
        .hit_pulse_o  (hitPulse),
        .miss_pulse_o (missPulse),
        .game_over_o  (gameOver)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] swVal, input logic restartVal);
        sw = swVal;
        restart = restartVal;
        tick();
        restart = 1'b0;
    endtask

    // Present a request, wait (bounded) for ready, complete the handshake.
    task automatic spawnLane(input int idx, input logic [1:0] lvl);
        int w;
        spawnBus.spawn_valid = 1'b1;
        spawnBus.spawn_index = 5'(idx);
        level = lvl;
        #1;
        w = 0;
        while (!spawnBus.spawn_ready && w < 40) begin
            tick();
            w++;
        end
        checkOutput("spawn_ready_wait", 32'(spawnBus.spawn_ready), 32'd1);
        tick();
        spawnBus.spawn_valid = 1'b0;
    endtask

    task automatic scoreHit(input int idx, input logic [1:0] lvl);
        spawnLane(idx, lvl);
        sw[idx] = 1'b1;
        tick();
        sw[idx] = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        spawnBus.spawn_valid = 1'b0;
        spawnBus.spawn_index = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        checkOutput("reset_led", 32'(led), 32'd0);
        checkOutput("reset_score", 32'(score), 32'd0);
        checkOutput("reset_misses", 32'(misses), 32'd0);
        checkOutput("reset_hit_pulse", 32'(hitPulse), 32'd0);
        checkOutput("reset_miss_pulse", 32'(missPulse), 32'd0);
        checkOutput("reset_game_over", 32'(gameOver), 32'd0);

        // Lane 5 level 0, hit after nine lit cycles
        spawnLane(5, 2'd0);
        repeat (8) begin
            checkOutput("A_led5_lit", 32'(led[5]), 32'd1);
            tick();
        end
        checkOutput("A_led5_ninth", 32'(led[5]), 32'd1);
        checkOutput("A_score_before", 32'(score), 32'd0);
        sw[5] = 1'b1;
        tick();
        checkOutput("A_led5_cleared", 32'(led[5]), 32'd0);
        checkOutput("A_score_after", 32'(score), 32'd1);
        checkOutput("A_hit_pulse", 32'(hitPulse), 32'd1);
        sw[5] = 1'b0;
        tick();
        checkOutput("A_hit_pulse_end", 32'(hitPulse), 32'd0);
        checkOutput("A_score_hold", 32'(score), 32'd1);

        // Lanes 1,2 fill the field; lane 3 waits for lane 1 to expire
        spawnLane(1, 2'd0);
        spawnLane(2, 2'd0);
        spawnBus.spawn_valid = 1'b1;
        spawnBus.spawn_index = 5'd3;
        #1;
        checkOutput("B_ready_full", 32'(spawnBus.spawn_ready), 32'd0);
        waited = 0;
        while (!spawnBus.spawn_ready && waited < 40) begin
            tick();
            waited++;
        end
        checkOutput("B_wait_cycles", 32'(waited), 32'd19);
        checkOutput("B_misses_one", 32'(misses), 32'd1);
        checkOutput("B_miss_pulse", 32'(missPulse), 32'd1);
        checkOutput("B_led_mid", 32'(led), 32'h4);
        tick();
        spawnBus.spawn_valid = 1'b0;
        checkOutput("B_led_lane3", 32'(led), 32'h8);
        checkOutput("B_misses_two", 32'(misses), 32'd2);
        sw[3] = 1'b1;
        tick();
        checkOutput("B_score_lane3", 32'(score), 32'd2);
        sw[3] = 1'b0;
        applyStimulus(sw, 1'b1);
        checkOutput("B_restart_score", 32'(score), 32'd0);
        checkOutput("B_restart_misses", 32'(misses), 32'd0);
        checkOutput("B_restart_over", 32'(gameOver), 32'd0);

        // Level 2 double hit, then climb to saturation
        spawnLane(0, 2'd2);
        spawnLane(4, 2'd2);
        sw[0] = 1'b1;
        sw[4] = 1'b1;
        tick();
        checkOutput("C_double_score", 32'(score), 32'd6);
        checkOutput("C_double_pulse", 32'(hitPulse), 32'd1);
        checkOutput("C_double_led", 32'(led), 32'd0);
        sw = '0;
        tick();
        repeat (80) scoreHit(7, 2'd2);
        checkOutput("C_score_246", 32'(score), 32'd246);
        repeat (4) scoreHit(8, 2'd1);
        checkOutput("C_score_254", 32'(score), 32'd254);
        spawnLane(0, 2'd2);
        spawnLane(4, 2'd2);
        sw[0] = 1'b1;
        sw[4] = 1'b1;
        tick();
        checkOutput("C_score_sat", 32'(score), 32'd255);
        sw = '0;
        tick();
        scoreHit(9, 2'd3);
        checkOutput("C_score_sat_hold", 32'(score), 32'd255);
        checkOutput("C_misses_zero", 32'(misses), 32'd0);
        applyStimulus(sw, 1'b1);

        // Hit on the same cycle as the final timer tick
        spawnLane(9, 2'd1);
        repeat (9) tick();
        checkOutput("D_led9_last", 32'(led[9]), 32'd1);
        sw[9] = 1'b1;
        tick();
        checkOutput("D_score", 32'(score), 32'd2);
        checkOutput("D_misses", 32'(misses), 32'd0);
        checkOutput("D_miss_pulse", 32'(missPulse), 32'd0);
        checkOutput("D_hit_pulse", 32'(hitPulse), 32'd1);
        checkOutput("D_led9_cleared", 32'(led[9]), 32'd0);
        sw[9] = 1'b0;
        tick();

        // Edges on unlit lane 7
        applyStimulus(18'h00080, 1'b0);
`ifdef WHACK_PENALTY_EN
        checkOutput("P_edge1", 32'(score), 32'd1);
`else
        checkOutput("P_edge1", 32'(score), 32'd2);
`endif
        applyStimulus('0, 1'b0);
        applyStimulus(18'h00080, 1'b0);
`ifdef WHACK_PENALTY_EN
        checkOutput("P_edge2", 32'(score), 32'd0);
`else
        checkOutput("P_edge2", 32'(score), 32'd2);
`endif
        applyStimulus('0, 1'b0);
        applyStimulus(18'h00080, 1'b0);
`ifdef WHACK_PENALTY_EN
        checkOutput("P_edge3_floor", 32'(score), 32'd0);
`else
        checkOutput("P_edge3_floor", 32'(score), 32'd2);
`endif
        applyStimulus('0, 1'b0);

        // Three expiries end the game
        applyStimulus('0, 1'b1);
        spawnLane(10, 2'd2);
        spawnLane(11, 2'd2);
        waited = 0;
        while (misses != 4'd2 && waited < 30) begin
            tick();
            waited++;
        end
        checkOutput("E_misses_two", 32'(misses), 32'd2);
        spawnLane(12, 2'd2);
        spawnLane(13, 2'd0);
        repeat (3) tick();
        checkOutput("E_not_over_yet", 32'(gameOver), 32'd0);
        checkOutput("E_led12_lit", 32'(led[12]), 32'd1);
        tick();
        checkOutput("E_game_over", 32'(gameOver), 32'd1);
        checkOutput("E_led_cleared", 32'(led), 32'd0);
        checkOutput("E_misses_three", 32'(misses), 32'd3);
        checkOutput("E_miss_pulse", 32'(missPulse), 32'd1);
        spawnBus.spawn_valid = 1'b1;
        spawnBus.spawn_index = 5'd0;
        #1;
        checkOutput("E_ready_over", 32'(spawnBus.spawn_ready), 32'd0);
        spawnBus.spawn_valid = 1'b0;
        applyStimulus(18'h02000, 1'b0);
        checkOutput("E_over_edge_score", 32'(score), 32'd0);
        checkOutput("E_over_misses", 32'(misses), 32'd3);
        applyStimulus('0, 1'b1);
        checkOutput("E_restart_over", 32'(gameOver), 32'd0);
        checkOutput("E_restart_score", 32'(score), 32'd0);
        checkOutput("E_restart_misses", 32'(misses), 32'd0);
        spawnBus.spawn_valid = 1'b1;
        spawnBus.spawn_index = 5'd0;
        #1;
        checkOutput("E_ready_again", 32'(spawnBus.spawn_ready), 32'd1);
        spawnBus.spawn_index = 5'd20;
        #1;
        checkOutput("E_ready_bad_index", 32'(spawnBus.spawn_ready), 32'd0);
        spawnBus.spawn_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
